// File: rtl/hwa_out_reader.sv
// hwa_out_reader
// Captures the packed multi-lane result bus of the stochastic FIR accelerator
// at fixed intervals after `start`, buffers whole frames in a small FIFO and
// streams them out one lane per valid/ready transfer.
//
// Optional feature macro: HWA_READER_FRAME_ID_EN
//   defined     - 8-bit frame sequence counter, stored with each frame and
//                 presented on frame_id for every lane of that frame
//   not defined - no counter or tag storage, frame_id tied to 0
//
// Ports
//   clock     in   sole clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   arms / re-arms capture (same pulse the accelerator sees)
//   stop      in   ends capture; wins over start
//   hwa_out   in   accelerator result bus, lane k at [(k+1)(N+1)-1 : k(N+1)]
//   m_data    out  lane value
//   m_lane    out  lane index of m_data
//   m_last    out  high on lane LANES-1
//   m_valid   out  word available
//   m_ready   in   consumer accepts word
//   frame_id  out  frame sequence number (0 when feature disabled)
//   busy      out  capture armed (WAIT or RUN)
//   overflow  out  sticky: a capture was dropped on a full FIFO
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | not capturing; FIFO may still drain
// WAIT   | counting down the initial latency to the first capture
// RUN    | capturing once every PERIOD cycles
module hwa_out_reader #(
   parameter int N       = 12,
   parameter int LANES   = 4,
   parameter int LATENCY = 4096,
   parameter int PERIOD  = 4096,
   parameter int DEPTH   = 4
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic [(N+1)*LANES-1:0]      hwa_out,
   output logic [N:0]                  m_data,
   output logic [$clog2(LANES)-1:0]    m_lane,
   output logic                        m_last,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [7:0]                  frame_id,
   output logic                        busy,
   output logic                        overflow
);

   localparam int W    = (N+1)*LANES;
   localparam int LW   = $clog2(LANES);
   localparam int AW   = $clog2(DEPTH);
   localparam int MAXV = (LATENCY > PERIOD) ? LATENCY : PERIOD;
   localparam int CW   = $clog2(MAXV + 1);

   localparam logic [CW-1:0] LAT_LD    = CW'(LATENCY - 1);
   localparam logic [CW-1:0] PER_LD    = CW'(PERIOD - 1);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           cap;

   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           pop;
   logic           wr_ok;

   logic           ld_en;
   logic           ld_valid;
   logic [AW-1:0]  ld_ptr;
   logic [LW-1:0]  ld_lane;
   logic [W-1:0]   ld_frame;
   logic [N:0]     ld_word;

   // start/stop cycles never capture, even when the counter hits zero
   assign cap = (state != S_IDLE) && !start && !stop && (cnt == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (stop) begin
         state <= S_IDLE;
         busy  <= 1'b0;
      end else if (start) begin
         state <= S_WAIT;
         cnt   <= LAT_LD;
         busy  <= 1'b1;
      end else begin
         case (state)
            S_WAIT, S_RUN: begin
               if (cnt == '0) begin
                  state <= S_RUN;
                  cnt   <= PER_LD;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // a frame leaves the FIFO only once its last lane has been transferred,
   // so a full FIFO can still accept a capture on that same edge
   assign pop   = m_valid && m_ready && m_last;
   assign wr_ok = cap && ((count < CNT_FULL) || pop);

   always_ff @(posedge clock) begin
      if (wr_ok) mem[wr_ptr] <= hwa_out;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: ;
         endcase
         if (cap && !wr_ok) overflow <= 1'b1;
      end
   end

   // Output word selection. The output register always holds lane m_lane of
   // the head frame; after the last lane it moves to lane 0 of the next frame
   // if one is already buffered (the one written this edge is not counted).
   always_comb begin
      ld_en    = !m_valid || m_ready;
      ld_valid = 1'b0;
      ld_ptr   = rd_ptr;
      ld_lane  = '0;
      if (m_valid && !m_last) begin
         ld_valid = 1'b1;
         ld_lane  = m_lane + LW'(1);
      end else if (m_valid) begin
         ld_ptr   = rd_ptr + AW'(1);
         ld_valid = (count > CNT_ONE);
      end else begin
         ld_valid = (count != '0);
      end
      ld_frame = mem[ld_ptr];
      ld_word  = ld_frame[int'(ld_lane)*(N+1) +: (N+1)];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_lane  <= '0;
         m_last  <= 1'b0;
      end else if (ld_en) begin
         m_valid <= ld_valid;
         if (ld_valid) begin
            m_data <= ld_word;
            m_lane <= ld_lane;
            m_last <= (ld_lane == LAST_LANE);
         end else begin
            m_lane <= '0;
            m_last <= 1'b0;
         end
      end
   end

`ifdef HWA_READER_FRAME_ID_EN
   logic [7:0] fid_cnt;
   logic [7:0] tags [DEPTH];

   // counts capture attempts, dropped ones included, so gaps reveal drops
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fid_cnt <= 8'd0;
      end else if (start && !stop && (state == S_IDLE)) begin
         fid_cnt <= 8'd0;
      end else if (cap) begin
         fid_cnt <= fid_cnt + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_ok) tags[wr_ptr] <= fid_cnt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_id <= 8'd0;
      end else if (ld_en && ld_valid) begin
         frame_id <= tags[ld_ptr];
      end
   end
`else
   assign frame_id = 8'd0;
`endif

endmodule

// File: tb/tb_hwa_out_reader.sv
module tb_hwa_out_reader;

   localparam int N     = 12;
   localparam int LANES = 4;
   localparam int W     = (N+1)*LANES;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          start   = 1'b0;
   logic          start2  = 1'b0;
   logic          stop    = 1'b0;
   logic          m_ready = 1'b0;
   logic [W-1:0]  hwa_out = '0;

   logic [N:0]    m_data,   m_data2;
   logic [1:0]    m_lane,   m_lane2;
   logic          m_last,   m_last2;
   logic          m_valid,  m_valid2;
   logic [7:0]    frame_id, frame_id2;
   logic          busy,     busy2;
   logic          overflow, overflow2;

   int checks = 0;
   int errors = 0;

   int vals [4]    = '{3, 7, 11, 15};
   int fa   [4][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};

   hwa_out_reader #(.N(N), .LANES(LANES), .LATENCY(8), .PERIOD(8), .DEPTH(2)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
      .hwa_out(hwa_out), .m_data(m_data), .m_lane(m_lane), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready), .frame_id(frame_id),
      .busy(busy), .overflow(overflow)
   );

   hwa_out_reader dut_def (
      .clock(clock), .reset_n(reset_n), .start(start2), .stop(1'b0),
      .hwa_out(hwa_out), .m_data(m_data2), .m_lane(m_lane2), .m_last(m_last2),
      .m_valid(m_valid2), .m_ready(1'b0), .frame_id(frame_id2),
      .busy(busy2), .overflow(overflow2)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   function automatic logic [W-1:0] pack(input int a, input int b, input int c, input int d);
      return {13'(d), 13'(c), 13'(b), 13'(a)};
   endfunction

   function automatic int efid(input int v);
`ifdef HWA_READER_FRAME_ID_EN
      return v & 255;
`else
      return 0;
`endif
   endfunction

   task automatic chk_word(input string tag, input int data, input int lane, input int fid);
      chk({tag, "_valid"}, 32'(m_valid), 1);
      chk({tag, "_data"},  32'(m_data), data);
      chk({tag, "_lane"},  32'(m_lane), lane);
      chk({tag, "_last"},  32'(m_last), (lane == LANES-1) ? 1 : 0);
      chk({tag, "_fid"},   32'(frame_id), efid(fid));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0; stop = 1'b0; start2 = 1'b0; m_ready = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;

      // reset values
      do_reset();
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data",  32'(m_data), 0);
      chk("rst_lane",  32'(m_lane), 0);
      chk("rst_last",  32'(m_last), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ovf",   32'(overflow), 0);
      chk("rst_fid",   32'(frame_id), 0);

      // basic stream: start at edge 0, capture at 8, words at 9..12
      hwa_out = pack(3, 7, 11, 15);
      m_ready = 1'b1;
      do_start();
      chk("busy_after_start", 32'(busy), 1);
      tick(8);
      chk("no_valid_at_capture", 32'(m_valid), 0);
      tick(1);
      for (int k = 0; k < 4; k++) begin
         chk_word("basic", vals[k], k, 0);
         tick(1);
      end
      chk("basic_drained", 32'(m_valid), 0);
      tick(4);
      chk_word("basic_f2", 3, 0, 1);

      // async reset with lane 2 pending
      tick(2);
      chk("pre_rst_lane", 32'(m_lane), 2);
      reset_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(m_valid), 0);
      chk("midrst_data",  32'(m_data), 0);
      chk("midrst_lane",  32'(m_lane), 0);
      chk("midrst_busy",  32'(busy), 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (m_valid) seen = 1'b1;
      end
      chk("no_residual", 32'(seen), 0);

      // backpressure
      do_reset();
      hwa_out = pack(3, 7, 11, 15);
      do_start();
      tick(9);
      chk_word("bp_first", 3, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("bp_hold_data", 32'(m_data), 3);
         chk("bp_hold_lane", 32'(m_lane), 0);
         chk("bp_hold_valid", 32'(m_valid), 1);
      end
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_word("bp_rel", vals[k], k, 0);
         tick(1);
      end
      chk_word("bp_f2", 3, 0, 1);
      do_stop();

      // overflow with DEPTH=2: third capture dropped
      do_reset();
      hwa_out = pack(fa[0][0], fa[0][1], fa[0][2], fa[0][3]);
      do_start();
      tick(8);
      hwa_out = pack(fa[1][0], fa[1][1], fa[1][2], fa[1][3]);
      tick(8);
      chk("ovf_before", 32'(overflow), 0);
      hwa_out = pack(fa[2][0], fa[2][1], fa[2][2], fa[2][3]);
      tick(8);
      chk("ovf_after_third", 32'(overflow), 1);
      hwa_out = pack(fa[3][0], fa[3][1], fa[3][2], fa[3][3]);
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk_word("ovf_f0", fa[0][k], k, 0);
         tick(1);
      end
      for (int k = 0; k < 4; k++) begin
         chk_word("ovf_f1", fa[1][k], k, 1);
         tick(1);
      end
      chk("ovf_gap", 32'(m_valid), 0);
      do_stop();
      chk_word("ovf_f3", fa[3][0], 0, 3);
      chk("ovf_stop_busy", 32'(busy), 0);
      tick(4);
      chk("ovf_end_valid", 32'(m_valid), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // full FIFO with m_last transfer on the capture edge
      do_reset();
      hwa_out = pack(fa[0][0], fa[0][1], fa[0][2], fa[0][3]);
      do_start();
      tick(8);
      hwa_out = pack(fa[1][0], fa[1][1], fa[1][2], fa[1][3]);
      tick(8);
      hwa_out = pack(fa[2][0], fa[2][1], fa[2][2], fa[2][3]);
      tick(4);
      m_ready = 1'b1;
      tick(3);
      chk_word("fp_last", fa[0][3], 3, 0);
      tick(1);
      chk("fp_no_ovf", 32'(overflow), 0);
      chk_word("fp_f1", fa[1][0], 0, 1);
      tick(4);
      chk_word("fp_f2", fa[2][0], 0, 2);
      do_stop();

      // re-arm in WAIT, then stop in RUN with a frame buffered
      do_reset();
      hwa_out = pack(fa[3][0], fa[3][1], fa[3][2], fa[3][3]);
      do_start();
      tick(4);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      chk("rearm_no_orig", 32'(m_valid), 0);
      tick(4);
      chk("rearm_at_capture", 32'(m_valid), 0);
      tick(1);
      chk_word("rearm_first", fa[3][0], 0, 0);
      do_stop();
      chk("stop_busy", 32'(busy), 0);
      tick(7);
      chk_word("stop_held", fa[3][0], 0, 0);
      m_ready = 1'b1;
      tick(3);
      chk_word("stop_drain", fa[3][3], 3, 0);
      tick(1);
      chk("stop_drained", 32'(m_valid), 0);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (m_valid) seen = 1'b1;
      end
      chk("stop_no_capture", 32'(seen), 0);

      // default LATENCY=4096
      do_reset();
      hwa_out = pack(fa[1][0], fa[1][1], fa[1][2], fa[1][3]);
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      chk("def_busy", 32'(busy2), 1);
      tick(4096);
      chk("def_not_yet", 32'(m_valid2), 0);
      tick(1);
      chk("def_valid", 32'(m_valid2), 1);
      chk("def_data",  32'(m_data2), fa[1][0]);
      chk("def_lane",  32'(m_lane2), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
